btn_debouncer: RTL
==================

// Module: btn_debouncer
// PURPOSE
//   Debounces one raw mechanical push-button input and emits a clean level plus
//   one-cycle rise/fall pulses. Sits directly upstream of the LED counter logic in
//   top: btn pin -> btn_debouncer -> db_rise drives the count-up of led[3:0].
//   Includes input synchronisation, so btn may be fully asynchronous to clk.
// PARAMETERS
//   SYNC_STAGES    2          flip-flop stages in the input synchroniser (>= 2)
//   STABLE_CYCLES  1_000_000  cycles btn must stay constant to be accepted (10 ms @ 100 MHz; >= 1)
// PORTS
//   clk       in   1  system clock, 100 MHz, all logic on rising edge
//   reset     in   1  asynchronous, active-high reset
//   btn       in   1  raw button input, asynchronous, bouncy
//   db_level  out  1  debounced, registered button level
//   db_rise   out  1  one-cycle pulse, registered, asserted with the 0->1 transition of db_level
//   db_fall   out  1  one-cycle pulse, registered, asserted with the 1->0 transition of db_level
// BEHAVIOUR
//   - Reset (async assert, sync release): sync chain = 0, state = ZERO, counter = 0,
//     db_level = 0, db_rise = 0, db_fall = 0. Reset mid-wait aborts the wait; no pulse emitted.
//   - Synchroniser: btn passes through SYNC_STAGES flops -> btn_s (delay = SYNC_STAGES edges).
//   - Counter width CW = $clog2(STABLE_CYCLES+1); unsigned down-counter, never wraps below 0.
//   - FSM states (Moore on state; outputs registered):
//       ZERO : btn_s=1 -> WAIT1, cnt <= STABLE_CYCLES-1; else stay.
//       WAIT1: btn_s=0 -> ZERO (bounce rejected, no output change);
//              btn_s=1 & cnt==0 -> ONE, db_level <= 1, db_rise <= 1; else cnt <= cnt-1.
//       ONE  : btn_s=0 -> WAIT0, cnt <= STABLE_CYCLES-1; else stay.
//       WAIT0: btn_s=1 -> ONE (bounce rejected);
//              btn_s=0 & cnt==0 -> ZERO, db_level <= 0, db_fall <= 1; else cnt <= cnt-1.
//     Illegal/unreachable encodings -> ZERO.
//   - db_rise/db_fall are high for exactly one cycle, then cleared the next edge; never both high.
//   - Acceptance: btn_s must read the new value on STABLE_CYCLES+1 consecutive edges
//     (entry edge + STABLE_CYCLES wait edges). Pulses of <= STABLE_CYCLES cycles are rejected.
//   - Latency: btn stable from edge E0 -> db_level/db_rise update at edge E0+SYNC_STAGES+STABLE_CYCLES.
//   - Any opposite sample during a WAIT restarts the full window on the next entry (no partial credit).
//   - db_level changes only in the WAIT->ONE / WAIT->ZERO transitions; holding btn never retriggers db_rise.
// STRUCTURE
//   - debounce_pkg: typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} db_state_t;
//     localparam int DB_STABLE_100MHZ_10MS = 1_000_000 (default for STABLE_CYCLES).
//   - Sub-module bit_synchronizer #(STAGES) (clk, reset, d, q): generic N-flop synchroniser,
//     reused for other asynchronous board inputs; btn_debouncer instantiates one.
//   - Remainder: one always_ff for state/cnt/outputs, one always_comb for next-state.
// TESTING  (bench: SYNC_STAGES=2, STABLE_CYCLES=4, 100 MHz clk, btn changed on falling edge)
//   1. Reset asserted 1 cycle, btn=0 -> db_level=0, db_rise=0, db_fall=0 throughout; state ZERO.
//   2. btn=1 for 4 cycles then 0 -> rejected: db_level stays 0, no db_rise, no db_fall.
//   3. btn=1 for 5 cycles then 0 -> db_rise pulse 1 cycle at edge E0+6, db_level=1; after
//      btn=0 held 5+ cycles, db_fall pulse 1 cycle, db_level=0.
//   4. Bouncy press: btn 1,0,1,1,0,1 then held 1 for 20 cycles -> exactly one db_rise, issued
//      6 edges after the last 0->1; db_level stays 1 while held, no repeat pulses.
//   5. Reset asserted mid-WAIT1 (cnt=2) -> outputs 0 immediately (async); after release with btn
//      held 1, db_rise arrives a full 6 edges after release, not earlier.
//   6. Two clean 5-cycle presses separated by 6 cycles of 0 -> exactly 2 db_rise and 2 db_fall pulses,
//      alternating; db_rise & db_fall never simultaneously 1 (assertion).

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and constants for the push-button debouncer.
package debounce_pkg;
    typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} db_state_t;
    localparam int DB_STABLE_100MHZ_10MS = 1_000_000;
endpackage

// File: rtl/bit_synchronizer.sv
// Generic N-flop synchroniser for a single asynchronous input bit.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];
endmodule

// File: rtl/btn_debouncer.sv
// Debounces one raw push-button input into a clean level plus one-cycle rise/fall pulses.
// state | meaning
// ZERO  | accepted level is 0, idle
// WAIT1 | synchronised input reads 1, counting down the stability window
// ONE   | accepted level is 1, idle
// WAIT0 | synchronised input reads 0, counting down the stability window
module btn_debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = DB_STABLE_100MHZ_10MS
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic db_level,
    output logic db_rise,
    output logic db_fall
);
    localparam int            CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic      btn_s;
    db_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic      level_q, level_d;
    logic      rise_q, rise_d;
    logic      fall_q, fall_d;

    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn),
        .q     (btn_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ZERO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // A contrary sample in a WAIT state drops back without keeping the count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ZERO: begin
                if (btn_s) begin
                    state_d = WAIT1;
                    cnt_d   = CNT_LOAD;
                end
            end
            WAIT1: begin
                if (!btn_s)             state_d = ZERO;
                else if (cnt_q == '0)   state_d = ONE;
                else                    cnt_d   = cnt_q - CNT_ONE;
            end
            ONE: begin
                if (!btn_s) begin
                    state_d = WAIT0;
                    cnt_d   = CNT_LOAD;
                end
            end
            WAIT0: begin
                if (btn_s)              state_d = ONE;
                else if (cnt_q == '0)   state_d = ZERO;
                else                    cnt_d   = cnt_q - CNT_ONE;
            end
            default: state_d = ZERO;
        endcase
    end

    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (state_q == WAIT1 && state_d == ONE) begin
            level_d = 1'b1;
            rise_d  = 1'b1;
        end
        if (state_q == WAIT0 && state_d == ZERO) begin
            level_d = 1'b0;
            fall_d  = 1'b1;
        end
    end

    assign db_level = level_q;
    assign db_rise  = rise_q;
    assign db_fall  = fall_q;
endmodule
